rf68000_nic_bus_master: RTL and testbench

//  Initiator (bus-master) side of the node NIC port. Turns one decoded network

---
 rtl/rf68000_nic_pkg.sv | 18 +
 rtl/rf68000_nic_bus_master.sv | 129 ++++++++++++
 tb/tb_rf68000_nic_bus_master.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf68000_nic_pkg.sv
// Shared types and constants for the rf68000 node NIC bus-master port.
package rf68000_nic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP,
    ACKLO
  } state_t;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  localparam int ID_W  = 4;

  localparam logic [DAT_W-1:0] NIC_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/rf68000_nic_bus_master.sv
// NIC initiator: turns one ring request into a single cyc/stb/ack bus cycle
// and hands the captured read data (or a timeout error) back to the ring.
module rf68000_nic_bus_master
  import rf68000_nic_pkg::*;
#(
  parameter int unsigned      TIMEOUT  = 255,
  parameter logic [DAT_W-1:0] ERR_DATA = NIC_ERR_DATA
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ID_W-1:0]  id,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [SEL_W-1:0] req_sel,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [DAT_W-1:0] req_dat,
  input  logic [ID_W-1:0]  req_src,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic [ID_W-1:0]  rsp_dst,
  output logic [ID_W-1:0]  rsp_src,
  output logic             m_cyc,
  output logic             m_stb,
  output logic             m_we,
  output logic [SEL_W-1:0] m_sel,
  output logic [ADR_W-1:0] m_adr,
  output logic [DAT_W-1:0] m_dato,
  input  logic             m_ack,
  input  logic [DAT_W-1:0] m_dati
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it never fires.
  localparam int             CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // NOTE: every register here uses <= so all branches see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      rsp_dst   <= '0;
      rsp_src   <= '0;
      m_cyc     <= 1'b0;
      m_stb     <= 1'b0;
      m_we      <= 1'b0;
      m_sel     <= '0;
      m_adr     <= '0;
      m_dato    <= '0;
    end else begin
      rsp_src <= id;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            m_cyc     <= 1'b1;
            m_stb     <= 1'b1;
            m_we      <= req_we;
            m_sel     <= req_sel;
            m_adr     <= req_adr;
            m_dato    <= req_dat;
            rsp_dst   <= req_src;
            req_ready <= 1'b0;
            cnt       <= '0;
            state     <= BUS;
          end else begin
            req_ready <= ~m_ack;
          end
        end

        BUS: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // Ack is checked first so a late ack beats the timeout on the same edge.
          if (m_ack) begin
            rsp_dat   <= m_we ? '0 : m_dati;
            rsp_err   <= 1'b0;
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            m_we      <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else if (timeout_hit) begin
            rsp_dat   <= ERR_DATA;
            rsp_err   <= 1'b1;
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (m_ack) begin
              state <= ACKLO;
            end else begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        ACKLO: begin
          // Responder still holds ack from the previous cycle; never overlap it.
          if (!m_ack) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf68000_nic_bus_master.sv
// Scoreboard bench for rf68000_nic_bus_master: directed requests, a modelled
// bus responder, and a monitor that checks every response against a queue.
module tb_rf68000_nic_bus_master;

  localparam logic [3:0] ID = 4'h5;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic [3:0]  dst;
    logic [3:0]  src;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_sel, req_src;
  logic [31:0] req_adr, req_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [3:0]  rsp_dst, rsp_src;
  logic        m_cyc, m_stb, m_we, m_ack;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dato, m_dati;

  int n_checks = 0;
  int n_err    = 0;

  // Responder model controls
  bit          ack_en    = 1'b1;
  int          ack_delay = 3;
  int          ack_hold  = 0;
  logic [31:0] rd_data   = 32'h0;
  int          rcnt      = 0;
  int          hold_left = 0;
  bit          seen;

  // Observation counters
  int   cyc_cnt  = 0;
  int   ackl_cnt = 0;
  int   viol     = 0;
  logic prev_cyc = 1'b0;

  rsp_t exp_q[$];
  rsp_t mon_e;

  rf68000_nic_bus_master #(.TIMEOUT(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id(ID),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat), .req_src(req_src),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_dst(rsp_dst), .rsp_src(rsp_src),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
    .m_adr(m_adr), .m_dato(m_dato), .m_ack(m_ack), .m_dati(m_dati)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk(input logic [31:0] d, input logic e, input logic [3:0] dst);
    mk = '{dat: d, err: e, dst: dst, src: ID};
  endfunction

  // Bus responder: acks after ack_delay strobed cycles, releases ack_hold
  // cycles later than the minimum one cycle after stb drops.
  always begin
    @(posedge clk_i);
    seen = m_cyc && m_stb;
    #1;
    if (rst_i) begin
      m_ack = 1'b0;
      rcnt  = 0;
    end else if (seen) begin
      if (ack_en && !m_ack) begin
        rcnt++;
        if (rcnt >= ack_delay) begin
          m_ack     = 1'b1;
          m_dati    = rd_data;
          hold_left = ack_hold;
        end
      end
    end else begin
      rcnt = 0;
      if (m_ack) begin
        if (hold_left > 0) hold_left--;
        else m_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_dat", rsp_dat, mon_e.dat);
        check("rsp_err", rsp_err, mon_e.err);
        check("rsp_dst", rsp_dst, mon_e.dst);
        check("rsp_src", rsp_src, mon_e.src);
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_cyc) cyc_cnt++;
    if (!m_cyc && m_ack && !rsp_valid) ackl_cnt++;
    if (m_cyc && !prev_cyc && m_ack) viol++;
    prev_cyc = m_cyc;
  end

  task automatic drive_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] src);
    req_we    = we;
    req_sel   = sel;
    req_adr   = adr;
    req_dat   = dat;
    req_src   = src;
    req_valid = 1'b1;
  endtask

  task automatic accept(input bit push, input rsp_t e);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      if (req_valid && req_ready) begin
        if (push) exp_q.push_back(e);
        #1 req_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 64'd1, 64'd0);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_sel   = '0;
    req_adr   = '0;
    req_dat   = '0;
    req_src   = '0;
    rsp_ready = 1'b1;
    m_ack     = 1'b0;
    m_dati    = '0;

    repeat (2) @(negedge clk_i);
    check("rst_ctrl", {req_ready, rsp_valid, m_cyc, m_stb, m_we, rsp_err}, 64'd0);
    check("rst_data", {rsp_dat, m_adr}, 64'd0);
    check("rst_ids", {rsp_dst, rsp_src, m_sel}, 64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("idle_ready", req_ready, 64'd1);

    // 1: read, ack after 3 strobed cycles
    cyc_cnt = 0;
    rd_data = 32'h1234_5678;
    drive_req(1'b0, 4'hF, 32'h0000_1000, 32'h0, 4'h3);
    accept(1'b1, mk(32'h1234_5678, 1'b0, 4'h3));
    drain();
    check("t1_cyc_len", cyc_cnt, 64'd4);

    // 2: write with partial byte lanes
    rd_data = 32'h7777_7777;
    drive_req(1'b1, 4'b0011, 32'hFF10_0040, 32'hA5A5_0F0F, 4'h7);
    accept(1'b1, mk(32'h0, 1'b0, 4'h7));
    @(negedge clk_i);
    check("t2_bus_ctrl", {m_cyc, m_stb, m_we, m_sel}, {1'b1, 1'b1, 1'b1, 4'b0011});
    check("t2_m_adr", m_adr, 32'hFF10_0040);
    check("t2_m_dato", m_dato, 32'hA5A5_0F0F);
    drain();

    // 3: no ack -> timeout after 8 cycles
    ack_en  = 1'b0;
    cyc_cnt = 0;
    drive_req(1'b0, 4'hF, 32'h0000_2000, 32'h0, 4'h9);
    accept(1'b1, mk(32'hFFFF_FFFF, 1'b1, 4'h9));
    drain();
    check("t3_cyc_len", cyc_cnt, 64'd8);
    ack_en = 1'b1;

    // 4: response back-pressure with a second request waiting
    rsp_ready = 1'b0;
    ack_delay = 1;
    rd_data   = 32'hCAFE_0001;
    drive_req(1'b0, 4'hF, 32'h0000_3000, 32'h0, 4'h2);
    accept(1'b1, mk(32'hCAFE_0001, 1'b0, 4'h2));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (rsp_valid) break;
    end
    check("t4_rsp_valid", rsp_valid, 64'd1);
    drive_req(1'b1, 4'hC, 32'h0000_3004, 32'h0BAD_F00D, 4'h4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("t4_hold", {rsp_valid, req_ready, m_cyc, rsp_err, rsp_dat},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001});
    end
    @(posedge clk_i);
    #1 rsp_ready = 1'b1;
    accept(1'b1, mk(32'h0, 1'b0, 4'h4));
    drain();

    // 5: responder holds ack 2 extra cycles; next cycle must wait in ACKLO
    ack_hold = 2;
    ack_delay = 2;
    rd_data  = 32'h5555_AAAA;
    ackl_cnt = 0;
    drive_req(1'b0, 4'hF, 32'h0000_4000, 32'h0, 4'h1);
    accept(1'b1, mk(32'h5555_AAAA, 1'b0, 4'h1));
    drive_req(1'b1, 4'hF, 32'h0000_4004, 32'h0000_0001, 4'h6);
    accept(1'b1, mk(32'h0, 1'b0, 4'h6));
    drain();
    repeat (4) @(negedge clk_i);
    check("t5_acklo_cycles", ackl_cnt, 64'd4);
    check("t5_no_overlap", viol, 64'd0);
    ack_hold = 0;

    // 6: reset in the middle of a bus cycle
    ack_en = 1'b0;
    drive_req(1'b0, 4'hF, 32'h0000_5000, 32'h0, 4'h8);
    accept(1'b0, mk(32'h0, 1'b0, 4'h8));
    repeat (3) @(negedge clk_i);
    check("t6_pre_cyc", m_cyc, 64'd1);
    rst_i = 1'b1;
    #1;
    check("t6_async_drop", {m_cyc, m_stb, rsp_valid, req_ready}, 64'd0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    ack_en    = 1'b1;
    ack_delay = 3;
    repeat (2) @(negedge clk_i);
    check("t6_idle", {req_ready, m_cyc, rsp_valid}, {1'b1, 1'b0, 1'b0});
    rd_data = 32'h0F0F_F0F0;
    drive_req(1'b0, 4'hF, 32'h0000_6000, 32'h0, 4'hB);
    accept(1'b1, mk(32'h0F0F_F0F0, 1'b0, 4'hB));
    drain();
    check("final_no_overlap", viol, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
